mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between instruction fetch (inst port, read-only) and the memory stage (data port, read/write).
- Arbitrates between the two, latches the winning request, and sequences the bus address/data handshake with one outstanding transaction.
- Returns completion to the correct requester; its i_data_ok/d_data_ok feed the hazard unit's stall logic.
- Supports cancelling an in-flight fetch on an exception/eret flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_cancel  in  1  flush: drop the current/pending fetch
- i_addr_ok  out  1  fetch request accepted
- i_data_ok  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_wr  in  1  1=write
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_addr_ok  out  1  data request accepted
- d_data_ok  out  1  data read valid or write done
- d_rdata  out  DATA_W  data read data
- req  out  1  bus request
- wr  out  1  bus write
- size  out  2  bus size
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- addr_ok  in  1  bus accepted address
- data_ok  in  1  bus data phase done
- rdata  in  DATA_W  bus read data

Behaviour:
- States: IDLE, REQ, RESP. Registered: state, grant (0=inst, 1=data), last (last grant served), cancelled, and the latched wr/size/addr/wdata.
- Reset (resetn=0, any state, mid-transaction included): state=IDLE, grant=0, last=0, cancelled=0, latches=0. All outputs 0: req, wr, size, addr, wdata, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, i_rdata, d_rdata.
- IDLE, selecting the request:
  - Only one of the effective requests active: grant it. Effective inst request = i_req & ~i_cancel; effective data request = d_req.
  - Both active: grant the one not equal to last. Reset last=0, so data wins the first tie.
- IDLE, on a grant:
  - Pulse the winner's addr_ok combinationally in the same cycle.
  - Latch its fields. Inst fields are wr=0, size=2, wdata=0.
  - Set last=grant and go to REQ.
- IDLE, no effective request: stay in IDLE; both addr_ok outputs stay 0.
- REQ:
  - req=1, with wr/size/addr/wdata driven from the latches.
  - On addr_ok go to RESP; req drops the next cycle.
- RESP:
  - req=0.
  - On data_ok: pulse the granted port's data_ok combinationally; rdata passes through to both i_rdata and d_rdata.
  - Go to IDLE. No new grant is made in the same cycle.
- Minimum transaction: 3 cycles (IDLE accept, REQ, RESP). data_ok is honoured only in RESP; data_ok in IDLE/REQ and addr_ok outside REQ are ignored.
- Cancel:
  - i_cancel=1 while grant=0 and state is REQ or RESP sets cancelled. The bus transaction still completes.
  - On completion, i_data_ok is suppressed; cancelled clears on return to IDLE.
  - i_cancel=1 in IDLE blocks acceptance of i_req that cycle.
  - i_cancel has no effect on data transactions.
- The two addr_ok outputs are never both 1; the two data_ok outputs are never both 1.
- Requester-side fields may change after addr_ok; the bus side uses only the latches.

Decomposition:
- Shared package (mips.svh): arb_state_t enum (IDLE/REQ/RESP), msize_t 2-bit size encoding, and the existing word_t for addr/data.
- Optional sub-module rr_arb2: combinational 2-way round-robin pick from two requests and last.

Test Plan:
- Inst only: i_req=1, i_addr=0xBFC00000; bus addr_ok after 1 cycle, data_ok 2 cycles later with rdata=0x3C080001 -> i_addr_ok in cycle 0; req=1, addr=0xBFC00000, wr=0; i_data_ok=1 with i_rdata=0x3C080001; d_data_ok stays 0.
- Data byte write: d_wr=1, d_size=0, d_addr=0x80000003, d_wdata=0xAB -> bus shows wr=1, size=0, addr=0x80000003, wdata=0xAB; d_data_ok one pulse; i_* stay 0.
- Simultaneous i_req and d_req after reset -> data granted first; inst granted on the next IDLE; a later tie goes to data again (alternation).
- Continuous ties for 4 transactions -> grant sequence data, inst, data, inst.
- i_cancel pulse during RESP of a fetch -> bus completes, i_data_ok stays 0, cancelled clears; the next fetch request is accepted normally.
- resetn low during REQ -> req=0 and state=IDLE immediately (async); after release, an idle bus with no requests keeps every output at 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } msize_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: requester 0 is instruction fetch, requester 1 is data.
module mem_bus_arbiter_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    valid = req0 | req1;
    pick  = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and the memory stage,
// one outstanding transaction at a time, with fetch cancellation on flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  arb_state_t        state;
  logic              grant;
  logic              last;
  logic              cancelled;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic eff_i_req;
  logic any_req;
  logic pick;
  logic accept;
  logic done;
  logic cancel_hit;

  assign eff_i_req  = i_req & ~i_cancel;
  assign accept     = (state == IDLE) & any_req;
  assign done       = (state == RESP) & data_ok;
  assign cancel_hit = i_cancel & ~grant & ((state == REQ) | (state == RESP));

  mem_bus_arbiter_rr_arb2 u_rr (
    .req0  (eff_i_req),
    .req1  (d_req),
    .last  (last),
    .valid (any_req),
    .pick  (pick)
  );

  // Transaction sequencer: accept and latch a request, run the address phase, wait for data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b0;
      cancelled <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            last  <= pick;
            state <= REQ;
            if (pick) begin
              wr_q    <= d_wr;
              size_q  <= d_size;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              wr_q    <= 1'b0;
              size_q  <= SIZE_WORD;
              addr_q  <= i_addr;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (cancel_hit) cancelled <= 1'b1;
          if (addr_ok) state <= RESP;
        end
        RESP: begin
          if (data_ok) begin
            state     <= IDLE;
            cancelled <= 1'b0;
          end else if (cancel_hit) begin
            cancelled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake pulses to the requesters and bus-side drive from the latched fields.
  always_comb begin
    i_addr_ok = accept & ~pick;
    d_addr_ok = accept & pick;
    i_data_ok = done & ~grant & ~cancelled & ~i_cancel;
    d_data_ok = done & grant;
    i_rdata   = done ? rdata : '0;
    d_rdata   = done ? rdata : '0;
    req       = (state == REQ);
    wr        = wr_q;
    size      = size_q;
    addr      = addr_q;
    wdata     = wdata_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run scored against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_cancel;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_done;
    logic        dropped;
  } txn_t;

  // Free-running clock.
  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_cancel  (i_cancel),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_rdata   (d_rdata),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req    = 1'b0;
    i_addr   = '0;
    i_cancel = 1'b0;
    d_req    = 1'b0;
    d_wr     = 1'b0;
    d_size   = 2'd0;
    d_addr   = '0;
    d_wdata  = '0;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    rdata    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_req"}, 32'(req), 32'd0);
    check_output({tag, "_wr"}, 32'(wr), 32'd0);
    check_output({tag, "_size"}, 32'(size), 32'd0);
    check_output({tag, "_addr"}, addr, 32'd0);
    check_output({tag, "_wdata"}, wdata, 32'd0);
    check_output({tag, "_handshakes"}, 32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 32'd0);
    check_output({tag, "_i_rdata"}, i_rdata, 32'd0);
    check_output({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // One full transaction: accept, address phase, optional response wait, completion, idle.
  task automatic do_txn(input string tag, input logic ireq, input logic dreq, input logic exp_data,
                        input logic [31:0] ia, input logic dwr, input logic [1:0] dsz,
                        input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] rd,
                        input int resp_wait, input logic cancel_first);
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    e_wr    = exp_data ? dwr : 1'b0;
    e_size  = exp_data ? dsz : 2'd2;
    e_addr  = exp_data ? da : ia;
    e_wdata = exp_data ? dwd : 32'd0;

    next_cycle();
    idle_inputs();
    i_req = ireq; i_addr = ia;
    d_req = dreq; d_wr = dwr; d_size = dsz; d_addr = da; d_wdata = dwd;
    #1;
    check_output({tag, "_i_addr_ok"}, 32'(i_addr_ok), 32'(!exp_data));
    check_output({tag, "_d_addr_ok"}, 32'(d_addr_ok), 32'(exp_data));

    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    i_addr = ~ia; d_addr = ~da; d_wdata = ~dwd; d_wr = ~dwr; d_size = ~dsz;
    addr_ok = 1'b1;
    #1;
    check_output({tag, "_req"}, 32'(req), 32'd1);
    check_output({tag, "_wr"}, 32'(wr), 32'(e_wr));
    check_output({tag, "_size"}, 32'(size), 32'(e_size));
    check_output({tag, "_addr"}, addr, e_addr);
    check_output({tag, "_wdata"}, wdata, e_wdata);

    for (int w = 0; w < resp_wait; w++) begin
      next_cycle();
      addr_ok  = 1'b0;
      data_ok  = 1'b0;
      i_cancel = cancel_first && (w == 0);
      #1;
      check_output({tag, "_wait_req"}, 32'(req), 32'd0);
      check_output({tag, "_wait_data_ok"}, 32'({i_data_ok, d_data_ok}), 32'd0);
    end

    next_cycle();
    addr_ok = 1'b0; i_cancel = 1'b0; data_ok = 1'b1; rdata = rd;
    #1;
    check_output({tag, "_done_req"}, 32'(req), 32'd0);
    check_output({tag, "_i_data_ok"}, 32'(i_data_ok), 32'(!exp_data && !cancel_first));
    check_output({tag, "_d_data_ok"}, 32'(d_data_ok), 32'(exp_data));
    if (exp_data) check_output({tag, "_d_rdata"}, d_rdata, rd);
    else if (!cancel_first) check_output({tag, "_i_rdata"}, i_rdata, rd);

    next_cycle();
    idle_inputs();
    #1;
    check_output({tag, "_after_handshakes"}, 32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 32'd0);
  endtask

  // Directed scenarios, then a randomized run against the reference model.
  initial begin
    txn_t cur;
    bit   busy;
    bit   hist[$];
    bit   ei, ed, win;

    idle_inputs();
    resetn = 1'b0;
    #1;
    check_all_zero("reset");
    next_cycle();
    next_cycle();
    resetn = 1'b1;

    do_txn("inst_only", 1'b1, 1'b0, 1'b0, 32'hBFC00000, 1'b0, 2'd0, 32'h0, 32'h0,
           32'h3C080001, 1, 1'b0);
    do_txn("data_wr_byte", 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 2'd0, 32'h80000003, 32'h000000AB,
           32'h0, 0, 1'b0);

    next_cycle();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;

    for (int k = 0; k < 4; k++) begin
      do_txn("tie", 1'b1, 1'b1, (k % 2 == 0), 32'hBFC00100 + 32'(4 * k), 1'b0, 2'd1,
             32'h80001000 + 32'(k), 32'h0, 32'h11110000 + 32'(k), 0, 1'b0);
    end

    do_txn("cancel", 1'b1, 1'b0, 1'b0, 32'hBFC00200, 1'b0, 2'd0, 32'h0, 32'h0,
           32'hDEADBEEF, 2, 1'b1);
    do_txn("after_cancel", 1'b1, 1'b0, 1'b0, 32'hBFC00204, 1'b0, 2'd0, 32'h0, 32'h0,
           32'h24020007, 0, 1'b0);

    next_cycle();
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80002000; d_wdata = 32'hCAFEF00D;
    #1;
    check_output("rst_mid_d_addr_ok", 32'(d_addr_ok), 32'd1);
    next_cycle();
    d_req = 1'b0;
    #1;
    check_output("rst_mid_req_before", 32'(req), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    next_cycle();
    idle_inputs();
    next_cycle();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check_all_zero("idle_after_rst");
    end

    busy = 1'b0;
    cur  = '0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      i_req    = 1'($urandom_range(0, 1));
      i_addr   = $urandom();
      d_req    = 1'($urandom_range(0, 1));
      d_wr     = 1'($urandom_range(0, 1));
      d_size   = 2'($urandom_range(0, 2));
      d_addr   = $urandom();
      d_wdata  = $urandom();
      addr_ok  = 1'($urandom_range(0, 1));
      data_ok  = 1'($urandom_range(0, 1));
      rdata    = $urandom();
      i_cancel = ($urandom_range(0, 5) == 0);
      if (busy && cur.addr_done && !cur.is_data && data_ok) i_cancel = 1'b0;
      #1;
      if (!busy) begin
        check_output("rnd_idle_req", 32'(req), 32'd0);
        check_output("rnd_idle_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
        ei  = i_req && !i_cancel;
        ed  = d_req;
        win = 1'b0;
        if (ei || ed) begin
          if (ei && ed) win = (hist.size() == 0) ? 1'b1 : !hist[$];
          else          win = ed;
          hist.push_back(win);
          cur.is_data   = win;
          cur.wr        = win ? d_wr : 1'b0;
          cur.size      = win ? d_size : 2'd2;
          cur.addr      = win ? d_addr : i_addr;
          cur.wdata     = win ? d_wdata : 32'd0;
          cur.addr_done = 1'b0;
          cur.dropped   = 1'b0;
          busy          = 1'b1;
        end
        check_output("rnd_i_addr_ok", 32'(i_addr_ok), 32'((ei || ed) && !win));
        check_output("rnd_d_addr_ok", 32'(d_addr_ok), 32'((ei || ed) && win));
      end else begin
        check_output("rnd_busy_addr_ok", 32'({i_addr_ok, d_addr_ok}), 32'd0);
        if (!cur.addr_done) begin
          check_output("rnd_req", 32'(req), 32'd1);
          check_output("rnd_wr", 32'(wr), 32'(cur.wr));
          check_output("rnd_size", 32'(size), 32'(cur.size));
          check_output("rnd_addr", addr, cur.addr);
          check_output("rnd_wdata", wdata, cur.wdata);
          check_output("rnd_req_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
          if (i_cancel && !cur.is_data) cur.dropped = 1'b1;
          if (addr_ok) cur.addr_done = 1'b1;
        end else begin
          check_output("rnd_resp_req", 32'(req), 32'd0);
          if (data_ok) begin
            check_output("rnd_i_data_ok", 32'(i_data_ok), 32'(!cur.is_data && !cur.dropped));
            check_output("rnd_d_data_ok", 32'(d_data_ok), 32'(cur.is_data));
            if (cur.is_data) check_output("rnd_d_rdata", d_rdata, rdata);
            else if (!cur.dropped) check_output("rnd_i_rdata", i_rdata, rdata);
            busy = 1'b0;
          end else begin
            check_output("rnd_wait_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
            if (i_cancel && !cur.is_data) cur.dropped = 1'b1;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
